// File: rtl/la_clkdivsync.sv
// ---------------------------------------------------------------------------
// la_clkdivsync -- glitch-free programmable clock divider
//
// Derives one divided clock from clk. The divided clock is driven straight
// from a flop. Ratio changes and start/stop only take effect on period
// boundaries, so clkout never produces a runt high or low phase.
//
// Parameters
//   PROP    cell property string, passed through for implementation selection
//   N       width of the divide ratio and the internal period counter
//   DIVRST  divide ratio loaded at reset (2 .. 2**N-1)
//
// Ports
//   clk        source clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   en         run request (level)
//   cfg_valid  new divide ratio offered on cfg_div
//   cfg_div    requested divide ratio; 0 and 1 are treated as 2
//   cfg_ready  a new ratio can be accepted (no change outstanding)
//   clkout     divided clock, flop output
//   rise       one-cycle pulse in the first high cycle of each period
//   active     divider running (RUN or STOP)
// ---------------------------------------------------------------------------
module la_clkdivsync #(
    parameter        PROP   = "DEFAULT",
    parameter int    N      = 8,
    parameter int    DIVRST = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [N-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         clkout,
    output logic         rise,
    output logic         active
);

    localparam int NW = N + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   div_q, div_d;
    logic           pend_q, pend_d;
    logic [N-1:0]   pend_div_q, pend_div_d;
    logic           clkout_q, clkout_d;
    logic           rise_q, rise_d;

    logic           xfer;
    logic [N-1:0]   cfg_coerced;
    logic           wrap;
    logic [N-1:0]   cnt_inc;
    logic [NW-1:0]  high_len;

    always_comb begin
        xfer        = cfg_valid && !pend_q;
        cfg_coerced = (cfg_div < N'(2)) ? N'(2) : cfg_div;
        wrap        = (cnt_q == (div_q - N'(1)));
        // cnt never reaches D-1 before wrapping, so cnt+1 cannot overflow.
        cnt_inc     = cnt_q + N'(1);
        // High phase length ceil(D/2), one bit wider so D=2**N-1 is safe.
        high_len    = ({1'b0, div_q} + NW'(1)) >> 1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pend_div_d  = pend_div_q;
        clkout_d    = clkout_q;
        rise_d      = 1'b0;

        if (xfer) begin
            pend_d     = 1'b1;
            pend_div_d = cfg_coerced;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                clkout_d = 1'b0;
                // No period in flight, so a pending ratio is applied at once.
                if (pend_q) begin
                    div_d  = pend_div_q;
                    pend_d = 1'b0;
                end
                if (en) begin
                    state_d  = S_RUN;
                    clkout_d = 1'b1;
                    rise_d   = 1'b1;
                end
            end

            S_RUN, S_STOP: begin
                if (wrap) begin
                    cnt_d = '0;
                    // A ratio offered on the wrap cycle itself is used for
                    // the very next period, bypassing the pending register.
                    if (xfer) begin
                        div_d  = cfg_coerced;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        div_d  = pend_div_q;
                        pend_d = 1'b0;
                    end
                    if (en) begin
                        state_d  = S_RUN;
                        clkout_d = 1'b1;
                        rise_d   = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        clkout_d = 1'b0;
                    end
                end else begin
                    // Mid-period: keep counting whatever en does; en only
                    // decides whether the next boundary starts a new period.
                    cnt_d    = cnt_inc;
                    clkout_d = ({1'b0, cnt_inc} < high_len);
                    state_d  = en ? S_RUN : S_STOP;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                clkout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= N'(DIVRST);
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            clkout_q   <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            clkout_q   <= clkout_d;
            rise_q     <= rise_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign rise      = rise_q;
    assign active    = (state_q != S_IDLE);

    // Only the generic flop-based output stage exists; any other PROP value
    // selects it as well until a technology-specific cell is provided.
    generate
        if (PROP == "DEFAULT") begin : g_generic
            assign clkout = clkout_q;
        end else begin : g_tech_fallback
            assign clkout = clkout_q;
        end
    endgenerate

endmodule

// File: tb/tb_la_clkdivsync.sv
// ---------------------------------------------------------------------------
// tb_la_clkdivsync -- directed self-checking bench for la_clkdivsync
//
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a period away from the rising edge that updates the DUT.
// ---------------------------------------------------------------------------
module tb_la_clkdivsync;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         cfg_valid;
    logic [N-1:0] cfg_div;
    logic         cfg_ready;
    logic         clkout;
    logic         rise;
    logic         active;

    int n_checks = 0;
    int n_fail   = 0;

    la_clkdivsync #(
        .PROP   ("DEFAULT"),
        .N      (N),
        .DIVRST (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clkout    (clkout),
        .rise      (rise),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Walks n cycles comparing clkout/rise against MSB-first bit patterns.
    // cfg_valid is released after the first cycle so a single offer is made.
    task automatic expect_seq(input string tag, input int n,
                              input logic [31:0] clk_pat, input logic [31:0] rise_pat);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s clkout[%0d]", tag, i), 32'(clkout), 32'(clk_pat[n-1-i]));
            check($sformatf("%s rise[%0d]", tag, i), 32'(rise), 32'(rise_pat[n-1-i]));
            if (i == 0) cfg_valid = 1'b0;
        end
        $display("seq %s: %0d cycles checked", tag, n);
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // Reset values
        tick();
        tick();
        check("rst clkout", 32'(clkout), 32'd0);
        check("rst rise", 32'(rise), 32'd0);
        check("rst active", 32'(active), 32'd0);
        check("rst cfg_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;

        // DIVRST=2: 1,0,1,0...
        en = 1'b1;
        expect_seq("d2", 6, 32'b101010, 32'b101010);
        check("d2 active", 32'(active), 32'd1);
        en = 1'b0;                       // at cnt=1 (wrap) -> IDLE
        tick();
        check("d2 stop clkout", 32'(clkout), 32'd0);
        check("d2 stop active", 32'(active), 32'd0);

        // Transfer D=5 in IDLE: cfg_ready low for exactly one cycle
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        tick();
        check("idle cfg_ready low", 32'(cfg_ready), 32'd0);
        check("idle clkout", 32'(clkout), 32'd0);
        cfg_valid = 1'b0;
        tick();
        check("idle cfg_ready back", 32'(cfg_ready), 32'd1);
        en = 1'b1;
        expect_seq("d5", 10, 32'b1110011100, 32'b1000010000);

        // Offer D=4 on the wrap cycle: applies to the immediately next period
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        expect_seq("d4", 6, 32'b110011, 32'b100010);
        check("d4 cfg_ready", 32'(cfg_ready), 32'd1);

        // At cnt=1 of D=4 request D=3; hold a second offer (7) while pending
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        tick();
        check("d4->3 cnt2 clkout", 32'(clkout), 32'd0);
        check("d4->3 cnt2 cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_div = 8'd7;
        tick();
        check("d4->3 cnt3 clkout", 32'(clkout), 32'd0);
        check("d4->3 cnt3 cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        expect_seq("d3", 9, 32'b110110110, 32'b100100100);
        check("d3 cfg_ready", 32'(cfg_ready), 32'd1);

        // D=6 offered at the wrap, then en dropped at cnt=2
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        expect_seq("d6 head", 3, 32'b111, 32'b100);
        en = 1'b0;
        expect_seq("d6 tail", 3, 32'b000, 32'b000);
        check("d6 stop active", 32'(active), 32'd1);
        tick();
        check("d6 idle clkout", 32'(clkout), 32'd0);
        check("d6 idle active", 32'(active), 32'd0);
        check("d6 idle rise", 32'(rise), 32'd0);
        tick();
        check("d6 idle2 clkout", 32'(clkout), 32'd0);

        // en re-raised at cnt=4 during STOP: no gap
        en = 1'b1;
        expect_seq("d6 run", 3, 32'b111, 32'b100);
        en = 1'b0;
        tick();
        check("d6 cnt3 clkout", 32'(clkout), 32'd0);
        check("d6 cnt3 active", 32'(active), 32'd1);
        tick();
        check("d6 cnt4 clkout", 32'(clkout), 32'd0);
        en = 1'b1;
        tick();
        check("d6 cnt5 clkout", 32'(clkout), 32'd0);
        expect_seq("d6 resume", 6, 32'b111000, 32'b100000);
        check("d6 resume active", 32'(active), 32'd1);

        // cfg_div=0 and cfg_div=1 behave as D=2
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        expect_seq("div0", 4, 32'b1010, 32'b1010);
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        expect_seq("div1", 4, 32'b1010, 32'b1010);

        // D=8, pending change at cnt=3, then reset
        cfg_valid = 1'b1;
        cfg_div   = 8'd8;
        expect_seq("d8", 3, 32'b111, 32'b100);
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        tick();
        check("d8 cnt3 clkout", 32'(clkout), 32'd1);
        check("d8 cnt3 cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        reset     = 1'b1;
        tick();
        check("mid rst clkout", 32'(clkout), 32'd0);
        check("mid rst active", 32'(active), 32'd0);
        check("mid rst cfg_ready", 32'(cfg_ready), 32'd1);
        check("mid rst rise", 32'(rise), 32'd0);
        reset = 1'b0;
        // en still high: restarts with DIVRST=2, the pending 3 discarded
        expect_seq("post rst", 4, 32'b1010, 32'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
